// File: rtl/seg7_scan_display.sv
// Time-multiplexed 7-segment driver: double-buffered digit values, registered
// anode/segment outputs, optional leading-zero blanking and output polarity.
module seg7_scan_display #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 100000,
  parameter int BLANK_LEAD     = 1,
  parameter int ACTIVE_LOW_OUT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  output logic [NUM_DIGITS-1:0]     an,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic                      frame_done
);

  localparam int   DW  = $clog2(REFRESH_DIV);
  localparam int   IW  = $clog2(NUM_DIGITS);
  localparam logic INV = (ACTIVE_LOW_OUT != 0);

  logic [DW-1:0]           div;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] pending, disp;
  logic [NUM_DIGITS-1:0]   pending_dp, disp_dp;
  logic                    pend;
  logic                    tick, frame_end;

  logic [NUM_DIGITS-1:0]   blank;
  logic [NUM_DIGITS-1:0]   an_hot;
  logic [3:0]              cur_digit;
  logic                    cur_blank, cur_dp;
  logic [6:0]              seg_hot;
  logic                    zero_above;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'h0: decode = 7'h3F;  4'h1: decode = 7'h06;
      4'h2: decode = 7'h5B;  4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;  4'h5: decode = 7'h6D;
      4'h6: decode = 7'h7D;  4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;  4'h9: decode = 7'h6F;
      4'hA: decode = 7'h77;  4'hB: decode = 7'h7C;
      4'hC: decode = 7'h39;  4'hD: decode = 7'h5E;
      4'hE: decode = 7'h79;  default: decode = 7'h71;
    endcase
  endfunction

  assign tick      = (div == DW'(REFRESH_DIV - 1));
  assign frame_end = tick && (idx == IW'(NUM_DIGITS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div <= '0;
      idx <= '0;
    end else if (tick) begin
      div <= '0;
      idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
    end else begin
      div <= div + DW'(1);
    end
  end

  // A load landing on the frame-end tick bypasses the pending stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending    <= '0;
      pending_dp <= '0;
      disp       <= '0;
      disp_dp    <= '0;
      pend       <= 1'b0;
    end else if (frame_end) begin
      if (load) begin
        disp    <= value;
        disp_dp <= dp_in;
        pend    <= 1'b0;
      end else if (pend) begin
        disp    <= pending;
        disp_dp <= pending_dp;
        pend    <= 1'b0;
      end
    end else if (load) begin
      pending    <= value;
      pending_dp <= dp_in;
      pend       <= 1'b1;
    end
  end

  always_comb begin
    blank      = '0;
    an_hot     = '0;
    cur_digit  = '0;
    cur_blank  = 1'b0;
    cur_dp     = 1'b0;
    zero_above = 1'b1;
    // Walk from the most significant digit down so each digit knows whether
    // everything at and above it is zero.
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      zero_above = zero_above && (disp[4*(NUM_DIGITS-1-k) +: 4] == 4'h0);
      blank[NUM_DIGITS-1-k] = (BLANK_LEAD != 0) && (k != NUM_DIGITS - 1) && zero_above;
    end
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        an_hot[i] = 1'b1;
        cur_digit = disp[4*i +: 4];
        cur_blank = blank[i];
        cur_dp    = disp_dp[i];
      end
    end
    seg_hot = cur_blank ? 7'h00 : decode(cur_digit);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an         <= {NUM_DIGITS{INV}};
      seg        <= {7{INV}};
      dp         <= INV;
      frame_done <= 1'b0;
    end else begin
      an         <= an_hot ^ {NUM_DIGITS{INV}};
      seg        <= seg_hot ^ {7{INV}};
      dp         <= cur_dp ^ INV;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: cycle-accurate reference model checked every cycle,
// a table of decoded-digit vectors, directed buffering corners and random loads.
module tb_seg7_scan_display;

  localparam int N = 4;
  localparam int R = 4;
  localparam int F = N * R;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  always #5 clk = ~clk;

  seg7_scan_display #(
    .NUM_DIGITS(N),
    .REFRESH_DIV(R),
    .BLANK_LEAD(1),
    .ACTIVE_LOW_OUT(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .value(value),
    .dp_in(dp_in),
    .an(an),
    .seg(seg),
    .dp(dp),
    .frame_done(frame_done)
  );

  int total = 0;
  int bad = 0;

  // Model state: k counts rising edges since reset release.
  int          k;
  int          last_ix;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_disp_dp, m_pend_dp;
  bit          m_pflag;

  logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic [6:0] lit_segs(input logic [15:0] v, input int i);
    logic [15:0] upper;
    upper = v >> (4 * i);
    if (i > 0 && upper == 16'h0) return 7'h00;
    return font[upper[3:0]];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", nm, act, exp, k);
    end
  endtask

  // Called at a falling edge; applies inputs for one rising edge, then checks.
  task automatic cycle(input bit ld, input logic [15:0] v, input logic [3:0] d);
    int ix;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, e_fd;
    load = ld; value = v; dp_in = d;
    @(posedge clk);
    ix    = (k / R) % N;
    e_an  = ~(4'b0001 << ix);
    e_seg = ~lit_segs(m_disp, ix);
    e_dp  = ~m_disp_dp[ix];
    e_fd  = (k % F == F - 1);
    if (k % F == F - 1) begin
      if (ld) begin
        m_disp = v; m_disp_dp = d; m_pflag = 0;
      end else if (m_pflag) begin
        m_disp = m_pend; m_disp_dp = m_pend_dp; m_pflag = 0;
      end
    end else if (ld) begin
      m_pend = v; m_pend_dp = d; m_pflag = 1;
    end
    k++;
    last_ix = ix;
    @(negedge clk);
    load = 1'b0;
    chk("an", 32'(an), 32'(e_an));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
  endtask

  task automatic do_reset();
    #3 rst = 1'b0;
    #1;
    chk("rst_an", 32'(an), 32'h0F);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_fd", 32'(frame_done), 32'h0);
    @(negedge clk);
    chk("rst_hold_an", 32'(an), 32'h0F);
    rst = 1'b1;
    k = 0; m_disp = '0; m_disp_dp = '0; m_pend = '0; m_pend_dp = '0; m_pflag = 0;
  endtask

  typedef struct {
    logic [15:0] v;
    logic [3:0]  d;
    int          digit;
    logic [6:0]  seg_exp;
    logic        dp_exp;
  } vec_t;

  vec_t tbl [11];
  int   seen4;

  initial begin
    tbl[0]  = '{16'h00A3, 4'b0000, 0, 7'h30, 1'b1};
    tbl[1]  = '{16'h00A3, 4'b0000, 1, 7'h08, 1'b1};
    tbl[2]  = '{16'h00A3, 4'b0000, 2, 7'h7F, 1'b1};
    tbl[3]  = '{16'h00A3, 4'b0000, 3, 7'h7F, 1'b1};
    tbl[4]  = '{16'h0000, 4'b0100, 0, 7'h40, 1'b1};
    tbl[5]  = '{16'h0000, 4'b0100, 1, 7'h7F, 1'b1};
    tbl[6]  = '{16'h0000, 4'b0100, 2, 7'h7F, 1'b0};
    tbl[7]  = '{16'h5678, 4'b0000, 0, 7'h00, 1'b1};
    tbl[8]  = '{16'h5678, 4'b0000, 1, 7'h78, 1'b1};
    tbl[9]  = '{16'h5678, 4'b0000, 2, 7'h02, 1'b1};
    tbl[10] = '{16'h5678, 4'b0000, 3, 7'h12, 1'b1};

    do_reset();
    cycle(0, '0, '0);
    chk("first_enable", 32'(an), 32'h0E);
    for (int i = 0; i < 2 * F; i++) cycle(0, '0, '0);

    // Table vectors: inspect the chosen digit during the second frame after load.
    for (int t = 0; t < 11; t++) begin
      bit done;
      done = 0;
      cycle(1, tbl[t].v, tbl[t].d);
      for (int j = 1; j <= 2 * F; j++) begin
        cycle(0, '0, '0);
        if (!done && j > F && last_ix == tbl[t].digit) begin
          done = 1;
          chk($sformatf("tbl%0d_an", t), 32'(an), 32'(4'hF ^ (4'b0001 << tbl[t].digit)));
          chk($sformatf("tbl%0d_seg", t), 32'(seg), 32'(tbl[t].seg_exp));
          chk($sformatf("tbl%0d_dp", t), 32'(dp), 32'(tbl[t].dp_exp));
        end
      end
    end

    // Load exactly on the frame-end tick: shows in the very next frame.
    for (int i = 0; i < F && (k % F) != F - 1; i++) cycle(0, '0, '0);
    cycle(1, 16'h000F, 4'b0000);
    cycle(0, '0, '0);
    chk("tick_load_digit0", 32'(seg), 32'h0E);
    chk("tick_load_an", 32'(an), 32'h0E);

    // Two loads in one frame: the first is never shown.
    seen4 = 0;
    cycle(1, 16'h1234, 4'b0000);
    cycle(0, '0, '0);
    cycle(0, '0, '0);
    cycle(1, 16'h5678, 4'b0000);
    for (int i = 0; i < 2 * F; i++) begin
      cycle(0, '0, '0);
      if (an == 4'b1110 && seg == 7'h19) seen4++;
    end
    chk("last_load_wins", 32'(seen4), 32'h0);

    // Random loads, including values with leading zeros.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] rv;
      rv = 16'($urandom) >> (4 * $urandom_range(0, 3));
      cycle($urandom_range(0, 7) == 0, rv, 4'($urandom));
    end

    // Reset in the middle of a scan.
    for (int i = 0; i < 6; i++) cycle(0, '0, '0);
    do_reset();
    for (int i = 0; i < F + 2; i++) cycle(0, '0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
